uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receive engine and the successor to the fixed 8N1 receiver. It integrates its own baud/oversample counter, input synchroniser, start-bit validation and majority-vote sampling. Data width, parity mode and stop-bit count are configurable. Each received frame is delivered through a one-entry valid/ready output register with parity, framing and overrun status.

Parameters:
DATA_BITS, 8, payload bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits checked; legal values 1 or 2.
CLKS_PER_BIT, 434, clk cycles per bit period; must be >= 8.
SYNC_STAGES, 2, flip-flops in the rx_pin_in synchroniser; must be >= 2.

Ports:
clk  in  1  system clock; everything is on the rising edge.
rst  in  1  synchronous, active-high reset.
rx_en  in  1  receiver enable.
rx_pin_in  in  1  asynchronous serial line; idles high.
rx_data  out  DATA_BITS  received payload, LSB = first bit received.
rx_valid  out  1  rx_data and error flags are valid.
rx_ready  in  1  consumer accepts the frame when rx_valid & rx_ready.
parity_err  out  1  parity mismatch for the presented frame; 0 when PARITY=0.
frame_err  out  1  any checked stop bit sampled low for the presented frame.
overrun_err  out  1  one-cycle pulse: a completed frame was dropped.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: at a rising clk edge with rst high, all outputs go to 0, the FSM goes to IDLE, counters clear, and the synchroniser loads all-ones. rst overrides all other inputs, including mid-frame.
- Synchroniser: rx_pin_in passes through SYNC_STAGES flops to give rxs. Start detection uses rxs together with its previous value.
- Bit timing: a baud counter counts 0..CLKS_PER_BIT-1 and restarts on every start detection. The mid point is M = CLKS_PER_BIT/2 (integer division). The counter samples rxs at counts M-1, M and M+1, and the bit value is the 2-of-3 majority. The bit is evaluated at count M+1.
- FSM states and transitions:
  - IDLE: a falling edge on rxs (previous 1, current 0) with rx_en=1 moves to START.
  - START: if the majority vote is 1, this is a false start; return to IDLE, produce no output and set no error. If the vote is 0, move to DATA.
  - DATA: DATA_BITS bits, shifted LSB first; then go to PARITY if PARITY != 0, otherwise to STOP.
  - PARITY: compute expected parity = XOR of the payload, inverted for odd mode. Store mismatch as parity_err. Move to STOP.
  - STOP: sample STOP_BITS bits. Any low sample sets frame_err for the frame. After the last stop-bit evaluation, go to DELIVER.
  - DELIVER: one cycle, then IDLE.
- Delivery in DELIVER:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data, parity_err and frame_err, and set rx_valid=1 on the next edge.
  - Otherwise the new frame is discarded, the held frame is unchanged, and overrun_err pulses high for exactly one cycle.
- Errored frames (parity_err or frame_err) are still delivered with their flags set.
- Handshake: rx_valid stays high and rx_data and the flags stay stable until a cycle with rx_ready=1. rx_valid clears on the following edge unless a reload happens on that same edge. rx_ready while rx_valid=0 is ignored.
- Latency: rx_valid rises exactly one cycle after DELIVER.
- rx_en=0: the FSM returns to IDLE on the next edge and any partial frame is dropped silently. The output register and handshake keep working.
- Break or stuck-low line: after a frame error the FSM is back in IDLE. A new start requires rxs to go high and then fall again.
- Back-to-back frames: start detection is active in the cycle after DELIVER, so a start bit that begins during the last stop bit's second half is caught.

Test Plan:
1. DATA_BITS=8, PARITY=0, STOP_BITS=1, CLKS_PER_BIT=16. Send 0x55 and then 0xA3 back-to-back with rx_ready=1 -> two rx_valid pulses carrying 0x55 and 0xA3, all error flags 0, busy low between frames only in IDLE.
2. PARITY=2 (even). Send 0x07 with parity bit 1 (correct) -> parity_err=0. Send 0x07 with parity bit 0 -> rx_data=0x07 and parity_err=1.
3. Send 0x3C with the stop bit driven low -> rx_valid=1, rx_data=0x3C, frame_err=1. Hold the line low for 3 more bit times -> no further frame until the line goes high and falls again.
4. Glitch: drive rx_pin_in low for 4 cycles, then high (CLKS_PER_BIT=16) -> FSM returns to IDLE, rx_valid stays 0, no error flags.
5. Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data stays 0x11 and overrun_err pulses exactly 1 cycle. Assert rx_ready -> rx_valid drops on the next edge.
6. Assert rst during data bit 4 of a frame -> all outputs 0 and busy=0 on the next edge, no frame delivered. A subsequent 0x9E is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: input synchroniser, oversampled majority-vote bit timing,
// configurable data/parity/stop framing and a one-entry valid/ready output register.
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx_pin_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID_M1    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] MID       = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] MID_P1    = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_DELIVER
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_prev;
  logic [CW-1:0]          cnt;
  logic                   samp_a, samp_b;
  logic                   vote, eval;
  logic [3:0]             bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr_r, ferr_r;
  logic                   par_exp;

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign eval    = (cnt == MID_P1);
  assign vote    = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign par_exp = (^shreg) ^ (PARITY == 1);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '1;
      rxs_prev <= 1'b1;
      state    <= S_IDLE;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rx_pin_in};
      rxs_prev <= rxs;
      state    <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (rx_en && rxs_prev && !rxs) state_n = S_START;
      S_START:   if (eval) state_n = vote ? S_IDLE : S_DATA;
      S_DATA:    if (eval && bit_idx == LAST_DATA) state_n = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:     if (eval) state_n = S_STOP;
      S_STOP:    if (eval && stop_idx == LAST_STOP) state_n = S_DELIVER;
      S_DELIVER: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (!rx_en) state_n = S_IDLE;
  end

  // Counter is held at zero in IDLE, so entering START restarts bit timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      samp_a   <= 1'b0;
      samp_b   <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
    end else if (state == S_IDLE) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
    end else begin
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
      if (cnt == MID_M1) samp_a <= rxs;
      if (cnt == MID)    samp_b <= rxs;
      if (eval) begin
        case (state)
          S_DATA: begin
            shreg   <= {vote, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 4'd1;
          end
          S_PAR: perr_r <= (vote != par_exp);
          S_STOP: begin
            if (!vote) ferr_r <= 1'b1;
            stop_idx <= stop_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A reload on the accepting edge takes priority over clearing rx_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (state == S_DELIVER) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= perr_r;
          frame_err  <= ferr_r;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: stimulus pushes expected frames, a monitor pops and
// compares each accepted frame; directed scenarios plus randomized frames.
module tb_uart_rx_param;

  localparam int DB  = 8;
  localparam int PM  = 2;
  localparam int SB  = 1;
  localparam int CPB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_en = 1'b1;
  logic          rx_pin_in = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b1;
  logic          parity_err, frame_err, overrun_err, busy;

  typedef struct packed {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   ovr_seen = 0;
  int   ovr_exp = 0;
  int   ready_mode = 1;

  uart_rx_param #(
    .DATA_BITS(DB),
    .PARITY(PM),
    .STOP_BITS(SB),
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_en(rx_en),
    .rx_pin_in(rx_pin_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun_err(overrun_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Consumer: 0 = stall, 1 = always ready, 2 = random back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        default: rx_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (overrun_err) ovr_seen++;
      if (rx_valid && rx_ready) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_frame: got data=%h pe=%b fe=%b, none expected",
                   rx_data, parity_err, frame_err);
        end else begin
          mon_e = sb_q.pop_front();
          if (rx_data !== mon_e.d || parity_err !== mon_e.pe || frame_err !== mon_e.fe) begin
            miscompares++;
            $display("FAIL frame: got data=%h pe=%b fe=%b, expected data=%h pe=%b fe=%b",
                     rx_data, parity_err, frame_err, mon_e.d, mon_e.pe, mon_e.fe);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx_pin_in = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  // Reference framing: start, LSB-first payload, optional parity, stop bits.
  task automatic send_frame(input logic [DB-1:0] d, input bit bad_par, input bit bad_stop,
                            input bit expect_out);
    int  ones;
    bit  pbit;
    exp_t e;
    ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    pbit = ((ones % 2) == 1) ^ (PM == 1) ^ bad_par;
    e.d  = d;
    e.pe = (PM != 0) && bad_par;
    e.fe = bad_stop;
    if (expect_out) sb_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PM != 0) drive_bit(pbit);
    for (int i = 0; i < SB; i++) drive_bit(!bad_stop);
  endtask

  initial begin
    logic [DB-1:0] rd;
    bit bp, bs;
    repeat (4) @(negedge clk);
    check("reset_outputs", {23'd0, rx_valid, parity_err, frame_err, overrun_err, busy, rx_data}, 32'd0);
    rst = 1'b0;
    idle_bits(2);

    // Back-to-back frames
    send_frame(8'h55, 0, 0, 1);
    send_frame(8'hA3, 0, 0, 1);
    idle_bits(2);
    check("busy_idle_gap", {31'd0, busy}, 32'd0);
    check("queue_after_b2b", sb_q.size(), 0);

    // Parity good / bad
    send_frame(8'h07, 0, 0, 1);
    idle_bits(1);
    send_frame(8'h07, 1, 0, 1);
    idle_bits(2);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 0, 1, 1);
    repeat (3 * CPB) @(negedge clk);
    check("busy_break_low", {31'd0, busy}, 32'd0);
    idle_bits(2);
    check("queue_after_break", sb_q.size(), 0);
    send_frame(8'hC4, 0, 0, 1);
    idle_bits(2);

    // Start glitch
    @(negedge clk);
    rx_pin_in = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_on_glitch", {31'd0, busy}, 32'd1);
    rx_pin_in = 1'b1;
    idle_bits(2);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_flags", {29'd0, rx_valid, parity_err, frame_err}, 32'd0);

    // Overrun while stalled
    ready_mode = 0;
    send_frame(8'h11, 0, 0, 1);
    send_frame(8'h22, 0, 0, 0);
    ovr_exp++;
    idle_bits(1);
    check("overrun_pulses", ovr_seen, ovr_exp);
    check("held_frame", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h11});
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("valid_drop", {31'd0, rx_valid}, 32'd0);
    idle_bits(1);

    // Reset during data bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    @(negedge clk);
    rx_pin_in = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx_pin_in = 1'b1;
    @(negedge clk);
    check("mid_frame_reset", {23'd0, rx_valid, parity_err, frame_err, overrun_err, busy, rx_data}, 32'd0);
    rst = 1'b0;
    idle_bits(3);
    check("queue_after_reset", sb_q.size(), 0);
    send_frame(8'h9E, 0, 0, 1);
    idle_bits(2);

    // Randomized frames with back-pressure
    ready_mode = 2;
    for (int n = 0; n < 24; n++) begin
      rd = DB'($urandom);
      bp = ($urandom_range(0, 5) == 0);
      bs = ($urandom_range(0, 5) == 0);
      send_frame(rd, bp, bs, 1);
      idle_bits(bs ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2));
    end
    idle_bits(3);
    ready_mode = 1;
    idle_bits(1);
    check("scoreboard_drained", sb_q.size(), 0);
    check("overrun_total", ovr_seen, ovr_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
